calc_div: RTL and testbench
===========================

Name: calc_div

Overview:
- Iterative 16-bit integer divider. It is the inverse companion to the Booth multiplier in the MP calc unit.
- Computes quotient and remainder of A / B, signed or unsigned, using a radix-2 restoring algorithm.
- Latency is a fixed 17 cycles so the issue stage can schedule writeback statically.
- Result is packed into the 32-bit C bus used by the other calc units: C[31:16] = remainder, C[15:0] = quotient.

Parameters:
- WIDTH, 16, operand width. Only 16 is supported; the parameter exists for lint and checking only.
- CNT_W, 5, iteration counter width; must hold the value WIDTH.

Ports:
- clk  input  1  core clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- A  input  16  dividend; sampled only on an accepted START.
- B  input  16  divisor; sampled only on an accepted START.
- SIGNED  input  1  1 = two's-complement operands, 0 = unsigned; sampled on START.
- START  input  1  request; accepted only when READY=1.
- FLUSH  input  1  abort any operation in flight.
- READY  output  1  high when idle and able to accept START.
- VALID  output  1  one-cycle pulse; C holds a new result in that cycle.
- C  output  32  {remainder[15:0], quotient[15:0]}; holds its value until the next VALID.

Behaviour:
- Reset: state=IDLE, READY=1, VALID=0, C=0, counter=0, all internal registers 0.
- States: IDLE, CALC, FIX.
- IDLE:
  - START=1 at edge k latches the operand magnitudes |A| and |B| (plain values when SIGNED=0).
  - Also latches q_neg = SIGNED & (A[15]^B[15]) and r_neg = SIGNED & A[15].
  - Records div0 = (B==0) and ovf = SIGNED & (A==16'h8000) & (B==16'hFFFF).
  - Clears the partial remainder R (17 bits) and the counter; moves to CALC. READY drops to 0 after edge k.
- CALC, one step per edge:
  - Shift {R, Q} left by 1, bringing the next dividend MSB into R.
  - Compute T = R - {1'b0, |B|}. If T >= 0, then R = T and Q[0] = 1; otherwise Q[0] = 0.
  - Counter increments; after the 16th step (edge k+16) the state moves to FIX.
- FIX (edge k+17):
  - Quotient = q_neg ? -Q : Q.
  - Remainder = r_neg ? -R[15:0] : R[15:0]. The remainder takes the sign of the dividend (truncating division).
  - div0 overrides: quotient = 16'hFFFF, remainder = A as originally sampled (raw, not the magnitude).
  - ovf overrides: quotient = 16'h8000, remainder = 16'h0000.
  - C is registered, VALID=1 for exactly the cycle after edge k+17, state returns to IDLE, READY=1.
- Latency and throughput:
  - Latency is 17 cycles from START acceptance to VALID, regardless of operands (div0 and ovf included).
  - Throughput is 1 result per 18 cycles: START may be asserted in the same cycle VALID is high (READY is already 1).
- START while READY=0 is ignored; the operation in flight is unaffected and the request is not queued.
- FLUSH:
  - Priority is below rst and above START.
  - In CALC or FIX, FLUSH forces IDLE next edge; VALID stays 0 and C keeps its previous value.
  - In IDLE, FLUSH together with START means START is ignored.
- rst mid-operation: everything returns to reset values next edge, and C is cleared to 0.
- Width rules:
  - R is 17 bits so the subtract compare is exact.
  - Magnitude of 16'h8000 is handled as unsigned 32768, which is correct in 16-bit unsigned.
  - Negation is modulo 2^16.
- Unsigned mode never sets ovf; sign flags are forced to 0.

Test Plan:
- Unsigned: A=1000, B=7, SIGNED=0, START pulse -> after exactly 17 cycles VALID=1, C=32'h0006_008E (rem 6, quo 142); READY low for cycles 1-17.
- Signed mix: A=-7 (16'hFFF9), B=2, SIGNED=1 -> C=32'hFFFF_FFFD (rem -1, quo -3). Then A=7, B=-2 -> C=32'h0001_FFFD.
- Divide by zero: A=16'h1234, B=0, signed and unsigned -> C=32'h1234_FFFF at 17-cycle latency.
- Overflow: A=16'h8000, B=16'hFFFF, SIGNED=1 -> C=32'h0000_8000. Same operands with SIGNED=0 -> C=32'h8000_0000 (rem 32768, quo 0).
- Back-to-back and ignored START:
  - START held high continuously with new operands -> result every 18 cycles.
  - START during CALC with different operands -> ignored; first result is unchanged.
- Abort:
  - FLUSH at cycle 9 of an operation -> no VALID, READY=1 next cycle, C retains the prior result. A new START then completes normally.
  - rst at cycle 5 -> C=0, READY=1.

Source files
------------

// File: rtl/calc_div.sv
// calc_div: iterative 16-bit signed/unsigned restoring divider, fixed 17-cycle latency.
//   clk, rst          : clock, synchronous active-high reset
//   A, B, SIGNED      : dividend, divisor, signed mode (sampled on accepted START)
//   START, FLUSH      : request (taken when READY), abort in-flight operation
//   READY, VALID      : idle/accepting, one-cycle result strobe
//   C                 : {remainder, quotient}, held until the next VALID
module calc_div #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic               SIGNED,
    input  logic               START,
    input  logic               FLUSH,
    output logic               READY,
    output logic               VALID,
    output logic [2*WIDTH-1:0] C
);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_raw, b_mag, q;
    logic [WIDTH:0]   r;
    logic             q_neg, r_neg, div0, ovf;
    logic [WIDTH-1:0] a_mag, b_abs, quo, rem;
    logic [WIDTH:0]   r_sh, t;
    logic             ge;
    logic [2*WIDTH-1:0] res;
    always_comb begin
        a_mag = (SIGNED && A[WIDTH-1]) ? -A : A;
        b_abs = (SIGNED && B[WIDTH-1]) ? -B : B;
        // R stays below |B| after each step, so its low WIDTH bits carry everything
        r_sh  = {r[WIDTH-1:0], q[WIDTH-1]};
        t     = r_sh - {1'b0, b_mag};
        ge    = r_sh >= {1'b0, b_mag};
        quo   = q_neg ? -q : q;
        rem   = r_neg ? -r[WIDTH-1:0] : r[WIDTH-1:0];
        res   = div0 ? {a_raw, {WIDTH{1'b1}}}
              : ovf  ? {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}}
              : {rem, quo};
    end
    assign READY = state == IDLE;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            a_raw <= '0;
            b_mag <= '0;
            q     <= '0;
            r     <= '0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
            div0  <= 1'b0;
            ovf   <= 1'b0;
            VALID <= 1'b0;
            C     <= '0;
        end else begin
            VALID <= 1'b0;
            case (state)
                IDLE: if (START && !FLUSH) begin
                    a_raw <= A;
                    b_mag <= b_abs;
                    q     <= a_mag;
                    r     <= '0;
                    cnt   <= '0;
                    q_neg <= SIGNED & (A[WIDTH-1] ^ B[WIDTH-1]);
                    r_neg <= SIGNED & A[WIDTH-1];
                    div0  <= B == '0;
                    ovf   <= SIGNED & (A == {1'b1, {(WIDTH-1){1'b0}}}) & (B == {WIDTH{1'b1}});
                    state <= CALC;
                end
                CALC: begin
                    r     <= ge ? t : r_sh;
                    q     <= {q[WIDTH-2:0], ge};
                    cnt   <= cnt + 1'b1;
                    state <= FLUSH ? IDLE : (cnt == CNT_W'(WIDTH - 1)) ? FIX : CALC;
                end
                FIX: begin
                    if (!FLUSH) begin
                        C     <= res;
                        VALID <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_calc_div.sv
// tb_calc_div: table-driven self-checking bench for calc_div.
module tb_calc_div;
    logic        clk = 0, rst = 1, SIGNED = 0, START = 0, FLUSH = 0;
    logic [15:0] A = 0, B = 0;
    logic        READY, VALID;
    logic [31:0] C;
    int total = 0, bad = 0;

    calc_div dut (.clk(clk), .rst(rst), .A(A), .B(B), .SIGNED(SIGNED), .START(START),
                  .FLUSH(FLUSH), .READY(READY), .VALID(VALID), .C(C));

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic [31:0] c;
        string       nm;
    } vec_t;
    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Issue one operation and check the READY/VALID timeline plus the result.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                          input logic [31:0] exp, input string nm);
        logic ok;
        ok = 1;
        @(negedge clk);
        A = a; B = b; SIGNED = s; START = 1;
        @(negedge clk);
        START = 0;
        for (int j = 0; j <= 17; j++) begin
            if (j > 0) @(negedge clk);
            if (j < 17 && (READY !== 1'b0 || VALID !== 1'b0)) ok = 0;
            if (j == 17) begin
                if (READY !== 1'b1 || VALID !== 1'b1) ok = 0;
                chk({nm, "_c"}, C, exp);
            end
        end
        @(negedge clk);
        if (VALID !== 1'b0) ok = 0;
        chk({nm, "_timing"}, {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (VALID !== 1'b1 && n < 40);
    endtask

    initial begin
        int n;
        logic seen;
        vecs[0] = '{16'd1000, 16'd7,      1'b0, 32'h0006_008E, "u1000_7"};
        vecs[1] = '{16'hFFF9, 16'd2,      1'b1, 32'hFFFF_FFFD, "sm7_2"};
        vecs[2] = '{16'd7,    16'hFFFE,   1'b1, 32'h0001_FFFD, "s7_m2"};
        vecs[3] = '{16'h1234, 16'h0000,   1'b1, 32'h1234_FFFF, "div0_s"};
        vecs[4] = '{16'h1234, 16'h0000,   1'b0, 32'h1234_FFFF, "div0_u"};
        vecs[5] = '{16'h8000, 16'hFFFF,   1'b1, 32'h0000_8000, "ovf_s"};
        vecs[6] = '{16'h8000, 16'hFFFF,   1'b0, 32'h8000_0000, "ovf_u"};
        vecs[7] = '{16'd100,  16'd10,     1'b1, 32'h0000_000A, "s100_10"};
        vecs[8] = '{16'hFF9C, 16'hFFF9,   1'b1, 32'hFFFE_000E, "sm100_m7"};
        vecs[9] = '{16'hFFFF, 16'd1,      1'b0, 32'h0000_FFFF, "uffff_1"};

        repeat (2) @(negedge clk);
        rst = 0;
        chk("reset_state", {29'd0, READY, VALID, 1'b0}, {29'd0, 1'b1, 1'b0, 1'b0});
        chk("reset_c", C, 32'h0);

        foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].c, vecs[i].nm);

        // START held high; operand change during CALC must not disturb the first result
        @(negedge clk);
        A = 16'd1000; B = 16'd7; SIGNED = 0; START = 1;
        @(negedge clk);
        A = 16'd100; B = 16'd10;
        wait_valid(n);
        chk("b2b_lat1", n + 1, 18);
        chk("b2b_c1", C, 32'h0006_008E);
        wait_valid(n);
        START = 0;
        chk("b2b_period", n, 18);
        chk("b2b_c2", C, 32'h0000_000A);
        @(negedge clk);

        // FLUSH together with START in IDLE: nothing starts
        FLUSH = 1; START = 1; A = 16'd3; B = 16'd1;
        @(negedge clk);
        FLUSH = 0; START = 0;
        chk("flush_start_ready", {31'd0, READY}, 32'd1);

        // FLUSH at cycle 9
        @(negedge clk);
        A = 16'd5; B = 16'd2; SIGNED = 0; START = 1;
        @(negedge clk);
        START = 0;
        repeat (8) @(negedge clk);
        FLUSH = 1;
        @(negedge clk);
        FLUSH = 0;
        chk("flush_ready", {31'd0, READY}, 32'd1);
        chk("flush_c_kept", C, 32'h0000_000A);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (VALID === 1'b1) seen = 1;
        end
        chk("flush_no_valid", {31'd0, seen}, 32'd0);
        run_op(16'd5, 16'd2, 1'b0, 32'h0001_0002, "after_flush");

        // rst at cycle 5
        @(negedge clk);
        A = 16'd9; B = 16'd4; SIGNED = 0; START = 1;
        @(negedge clk);
        START = 0;
        repeat (4) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("midrst_c", C, 32'h0);
        chk("midrst_ready", {31'd0, READY}, 32'd1);
        run_op(16'd9, 16'd4, 1'b0, 32'h0001_0002, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
